hazard_ctrl: RTL
================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core: drives PC write-enable and IF/ID write/flush,
//  inserts ID/EX bubbles and freezes EX/MEM. Arbitrates load-use, taken-branch, imem-miss and
//  dmem-wait events. Tracks a dmem-wait FSM with timeout and exposes stall/flush perf counters.
// PARAMETERS
//  REG_W     5   register-specifier width
//  MAX_WAIT  15  dmem wait cycles tolerated before mem_timeout (1..2^WAIT_W-1)
//  WAIT_W    4   width of wait counter
//  CNT_W     16  width of perf counters (saturating)
// PORTS
//  clk           in  1      rising-edge clock
//  rst           in  1      synchronous, active-high reset
//  id_rs         in  REG_W  rs of instruction in IF/ID
//  id_rt         in  REG_W  rt of instruction in IF/ID
//  id_uses_rs    in  1      ID instruction reads rs
//  id_uses_rt    in  1      ID instruction reads rt
//  ex_rt         in  REG_W  destination of instruction in ID/EX
//  ex_mem_read   in  1      ID/EX instruction is a load
//  br_taken      in  1      branch/jump resolved taken this cycle
//  imem_ready    in  1      instruction fetch data valid
//  dmem_req      in  1      MEM stage access in progress
//  dmem_ready    in  1      dmem completes this cycle
//  wpc           out 1      PC write enable
//  wir           out 1      IF/ID write enable
//  ir_flush      out 1      IF/ID loads NOP (0x00000000) instead of fetch data
//  idex_bubble   out 1      ID/EX loads NOP control
//  pipe_freeze   out 1      ID/EX, EX/MEM, MEM/WB hold
//  mem_timeout   out 1      sticky: dmem wait exceeded MAX_WAIT
//  stall_cnt     out CNT_W  cycles with wpc=0
//  flush_cnt     out CNT_W  cycles with ir_flush=1
// BEHAVIOUR
//  Reset (rst=1 at edge): state=RUN, wait_cnt=0, mem_timeout=0, counters=0. While rst=1,
//   outputs forced: wpc=0 wir=1 ir_flush=1 idex_bubble=1 pipe_freeze=0.
//  FSM states: RUN, MEM_WAIT, TIMEOUT (registered); control outputs are combinational.
//  mem_busy = dmem_req & ~dmem_ready.
//  lu_haz = ex_mem_read & (ex_rt!=0) & ((id_uses_rs & id_rs==ex_rt) | (id_uses_rt & id_rt==ex_rt)).
//  Priority per cycle (first match wins):
//   1 mem_busy or state==TIMEOUT: wpc=0 wir=0 ir_flush=0 idex_bubble=0 pipe_freeze=1.
//   2 br_taken: wpc=1 wir=1 ir_flush=1 idex_bubble=1 (branch overrides load-use).
//   3 lu_haz: wpc=0 wir=0 idex_bubble=1 ir_flush=0 (exactly 1 bubble per hazard).
//   4 ~imem_ready: wpc=0 wir=1 ir_flush=1 idex_bubble=0.
//   5 else: wpc=1 wir=1, others 0.
//  Transitions:
//   RUN -> MEM_WAIT when mem_busy; wait_cnt <= 1.
//   MEM_WAIT: dmem_ready -> RUN, wait_cnt<=0; else wait_cnt++ ; if wait_cnt==MAX_WAIT and
//    still busy -> TIMEOUT, mem_timeout<=1.
//   TIMEOUT: terminal until rst; pipeline frozen; mem_timeout stays 1.
//  dmem_ready in same cycle as dmem_req: no stall, state stays RUN.
//  Counters: stall_cnt++ when wpc=0 (outside reset); flush_cnt++ when ir_flush=1 (outside reset);
//   both saturate at 2^CNT_W-1, never wrap.
//  Reset mid-stall/MEM_WAIT/TIMEOUT: next cycle RUN, counters cleared, no residual bubble.
//  Register-0 target never causes load-use stall.
// TESTING
//  T1 ex_mem_read=1 ex_rt=8 id_rs=8 id_uses_rs=1 one cycle -> wpc=0 wir=0 idex_bubble=1
//     for 1 cycle, stall_cnt=1; same with ex_rt=0 -> no stall.
//  T2 lu_haz and br_taken same cycle -> wpc=1 ir_flush=1 idex_bubble=1, flush_cnt+1, stall_cnt +0.
//  T3 dmem_req=1, dmem_ready low 3 cycles then high -> pipe_freeze=1 for 3 cycles, state
//     MEM_WAIT->RUN, stall_cnt=3, mem_timeout=0.
//  T4 dmem_req=1 dmem_ready=0 for 20 cycles (MAX_WAIT=15) -> mem_timeout=1 after 16th wait
//     cycle, frozen thereafter; rst=1 one cycle -> RUN, mem_timeout=0, counters 0.
//  T5 imem_ready=0 for 2 cycles -> wpc=0 wir=1 ir_flush=1 each cycle, flush_cnt=2.
//  T6 force stall_cnt to 0xFFFE (CNT_W=16), 3 more stall cycles -> stall_cnt=0xFFFF held.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for the 5-stage MIPS core.
// Resolves load-use, taken-branch, imem-miss and dmem-wait events into
// PC/IF-ID/ID-EX/EX-MEM control. A small FSM tracks how long a data-memory
// access has been outstanding and latches a sticky timeout. Two saturating
// counters report stall and flush cycles.
module hazard_ctrl #(
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  input  logic             br_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             wpc,
  output logic             wir,
  output logic             ir_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(MAX_WAIT);

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_cnt_nxt_s;
  logic                timeout_set_s;
  logic                mem_timeout_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [CNT_W-1:0]    flush_cnt_r;

  logic                mem_busy_s;
  logic                lu_haz_s;
  logic                wpc_s;
  logic                wir_s;
  logic                ir_flush_s;
  logic                idex_bubble_s;
  logic                pipe_freeze_s;

  // An access that completes in the same cycle it is requested costs nothing.
  assign mem_busy_s = dmem_req & ~dmem_ready;

  // A load writing $zero can never feed a real dependency, so it is excluded.
  assign lu_haz_s = ex_mem_read & (ex_rt != {REG_W{1'b0}}) &
                    ((id_uses_rs & (id_rs == ex_rt)) |
                     (id_uses_rt & (id_rt == ex_rt)));

  // Prioritised pipeline control; memory stall dominates, branch beats load-use.
  always_comb begin
    wpc_s         = 1'b1;
    wir_s         = 1'b1;
    ir_flush_s    = 1'b0;
    idex_bubble_s = 1'b0;
    pipe_freeze_s = 1'b0;
    if (rst) begin
      wpc_s         = 1'b0;
      wir_s         = 1'b1;
      ir_flush_s    = 1'b1;
      idex_bubble_s = 1'b1;
      pipe_freeze_s = 1'b0;
    end else if (mem_busy_s || (state_r == TIMEOUT)) begin
      wpc_s         = 1'b0;
      wir_s         = 1'b0;
      ir_flush_s    = 1'b0;
      idex_bubble_s = 1'b0;
      pipe_freeze_s = 1'b1;
    end else if (br_taken) begin
      wpc_s         = 1'b1;
      wir_s         = 1'b1;
      ir_flush_s    = 1'b1;
      idex_bubble_s = 1'b1;
    end else if (lu_haz_s) begin
      wpc_s         = 1'b0;
      wir_s         = 1'b0;
      ir_flush_s    = 1'b0;
      idex_bubble_s = 1'b1;
    end else if (!imem_ready) begin
      wpc_s         = 1'b0;
      wir_s         = 1'b1;
      ir_flush_s    = 1'b1;
      idex_bubble_s = 1'b0;
    end else begin
      wpc_s         = 1'b1;
      wir_s         = 1'b1;
      ir_flush_s    = 1'b0;
      idex_bubble_s = 1'b0;
    end
  end

  // Dmem-wait FSM next state: count outstanding cycles, give up after MAX_WAIT.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    timeout_set_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (mem_busy_s) begin
          state_nxt_s    = MEM_WAIT;
          wait_cnt_nxt_s = {{(WAIT_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end
      end
      MEM_WAIT: begin
        if (!mem_busy_s) begin
          state_nxt_s    = RUN;
          wait_cnt_nxt_s = {WAIT_W{1'b0}};
        end else if (wait_cnt_r == WAIT_LIM) begin
          state_nxt_s    = TIMEOUT;
          timeout_set_s  = 1'b1;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + {{(WAIT_W-1){1'b0}}, 1'b1};
        end
      end
      TIMEOUT: begin
        state_nxt_s = TIMEOUT;
      end
      default: begin
        state_nxt_s    = RUN;
        wait_cnt_nxt_s = {WAIT_W{1'b0}};
      end
    endcase
  end

  // FSM state, wait counter and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= RUN;
      wait_cnt_r    <= {WAIT_W{1'b0}};
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      wait_cnt_r    <= wait_cnt_nxt_s;
      mem_timeout_r <= mem_timeout_r | timeout_set_s;
    end
  end

  // Saturating perf counters for PC-stall and IF/ID-flush cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      flush_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (!wpc_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (ir_flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

  assign wpc         = wpc_s;
  assign wir         = wir_s;
  assign ir_flush    = ir_flush_s;
  assign idex_bubble = idex_bubble_s;
  assign pipe_freeze = pipe_freeze_s;
  assign mem_timeout = mem_timeout_r;
  assign stall_cnt   = stall_cnt_r;
  assign flush_cnt   = flush_cnt_r;

endmodule
